// File: rtl/mcu_rocstar_rx_if.sv
// ROCSTAR->MCU receive-side bundle: incoming word/counter plus decoded status.
// RX_ERR_COUNT_EN adds the err_count/err_clr pair.
interface mcu_rocstar_rx_if;
    logic [7:0]  from_roc;
    logic [15:0] local_ctr;
    logic        locked;
    logic        single_valid;
    logic [15:0] single_ts;
    logic [6:0]  single_fine;
    logic        idle_ok;
    logic        err_pulse;
    logic [1:0]  err_code;
`ifdef RX_ERR_COUNT_EN
    logic [15:0] err_count;
    logic        err_clr;

    modport master (
        output from_roc, local_ctr, err_clr,
        input  locked, single_valid, single_ts, single_fine,
               idle_ok, err_pulse, err_code, err_count
    );
    modport slave (
        input  from_roc, local_ctr, err_clr,
        output locked, single_valid, single_ts, single_fine,
               idle_ok, err_pulse, err_code, err_count
    );
`else
    modport master (
        output from_roc, local_ctr,
        input  locked, single_valid, single_ts, single_fine,
               idle_ok, err_pulse, err_code
    );
    modport slave (
        input  from_roc, local_ctr,
        output locked, single_valid, single_ts, single_fine,
               idle_ok, err_pulse, err_code
    );
`endif
endinterface

// File: rtl/mcu_rocstar_rx.sv
// MCU-side receiver for the ROCSTAR->MCU word link: framing/phase/counter checks,
// lock tracking and timestamped single events. Optional macro: RX_ERR_COUNT_EN.
module mcu_rocstar_rx #(
    parameter int LINK_DELAY = 1,
    parameter int LOCK_COUNT = 8
) (
    input logic            clk,
    input logic            rst,
    mcu_rocstar_rx_if.slave bus
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} lock_state_t;

    lock_state_t state;
    logic [7:0]  good_cnt;
    logic        seq_valid;
    logic [1:0]  exp_phase;

    logic [15:0] exp_ctr;
    logic [1:0]  phase;
    logic [3:0]  nibble;
    logic [3:0]  exp_nibble;
    logic        is_idle;
    logic        is_single;
    logic        hdr_err;
    logic        seq_err;
    logic        mis_err;
    logic        any_err;
    logic        good_idle;
    logic [1:0]  code;

    assign exp_ctr   = bus.local_ctr - 16'(LINK_DELAY);
    assign phase     = bus.from_roc[3:2];
    assign nibble    = {bus.from_roc[5:4], bus.from_roc[1:0]};
    assign is_idle   = (bus.from_roc[7:6] == 2'b01);
    assign is_single = bus.from_roc[7];
    assign hdr_err   = (bus.from_roc[7:6] == 2'b00);

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        exp_nibble = exp_ctr[3:0];
        case (phase)
            2'd1:    exp_nibble = exp_ctr[7:4];
            2'd2:    exp_nibble = exp_ctr[11:8];
            2'd3:    exp_nibble = exp_ctr[15:12];
            default: exp_nibble = exp_ctr[3:0];
        endcase
    end

    assign seq_err   = is_idle && seq_valid && (phase != exp_phase);
    assign mis_err   = is_idle && (nibble != exp_nibble);
    assign any_err   = hdr_err || seq_err || mis_err;
    assign good_idle = is_idle && !seq_err && !mis_err;
    // Priority: header, then sequence, then counter mismatch.
    assign code      = hdr_err ? 2'd1 : (seq_err ? 2'd2 : 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= HUNT;
            good_cnt         <= '0;
            seq_valid        <= 1'b0;
            exp_phase        <= '0;
            bus.locked       <= 1'b0;
            bus.single_valid <= 1'b0;
            bus.single_ts    <= '0;
            bus.single_fine  <= '0;
            bus.idle_ok      <= 1'b0;
            bus.err_pulse    <= 1'b0;
            bus.err_code     <= '0;
        end else begin
            bus.idle_ok   <= good_idle;
            bus.err_pulse <= any_err;
            if (any_err)
                bus.err_code <= code;

            // Phase tracker follows the received phase, so one bad word resyncs it.
            if (is_idle) begin
                exp_phase <= phase + 2'd1;
                seq_valid <= 1'b1;
            end else if (is_single) begin
                exp_phase <= 2'd0;
                seq_valid <= 1'b1;
            end else begin
                exp_phase <= 2'd0;
                seq_valid <= 1'b0;
            end

            bus.single_valid <= is_single && (state == LOCKED);
            if (is_single && (state == LOCKED)) begin
                bus.single_ts   <= exp_ctr;
                bus.single_fine <= bus.from_roc[6:0];
            end

            case (state)
                HUNT, CHECK: begin
                    if (any_err) begin
                        state      <= HUNT;
                        good_cnt   <= '0;
                        bus.locked <= 1'b0;
                    end else if (good_idle) begin
                        good_cnt <= good_cnt + 8'd1;
                        if (good_cnt + 8'd1 == 8'(LOCK_COUNT)) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                        end else begin
                            state      <= CHECK;
                            bus.locked <= 1'b0;
                        end
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state      <= HUNT;
                        good_cnt   <= '0;
                        bus.locked <= 1'b0;
                    end
                end
                default: begin
                    state      <= HUNT;
                    good_cnt   <= '0;
                    bus.locked <= 1'b0;
                end
            endcase
        end
    end

`ifdef RX_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            bus.err_count <= '0;
        else if (bus.err_clr)
            bus.err_count <= '0;
        else if (any_err && (bus.err_count != 16'hFFFF))
            bus.err_count <= bus.err_count + 16'd1;
    end
`endif

endmodule

// File: doc/mcu_rocstar_rx.md
Name: mcu_rocstar_rx

Overview:
MCU-side receiver for the 8-bit ROCSTAR→MCU link. It is the direct consumer of the word stream the ROCSTAR link FSM produces. It decodes IDLE words, whose 4-bit payload carries successive nibbles of the ROCSTAR 16-bit clock counter, and SINGLE words, which carry a 7-bit fine offset. It checks framing, the phase sequence and counter alignment against the local MCU counter, maintains a link-lock state, and emits timestamped single-photon events for the coincidence logic.

Parameters:
LINK_DELAY, 1, cycles between ROCSTAR counter sample and word arrival on from_roc; expected counter = local_ctr - LINK_DELAY (mod 2^16)
LOCK_COUNT, 8, consecutive error-free IDLE words required to declare lock (legal range 1..255)

Ports:
clk  in  1  100 MHz system clock
rst  in  1  synchronous reset, active-high
from_roc  in  8  word from ROCSTAR, one per clk
local_ctr  in  16  MCU clock counter, synchronised to ROCSTAR by SPWORD 0x1111
locked  out  1  link locked
single_valid  out  1  one-cycle pulse: single-photon event
single_ts  out  16  local_ctr - LINK_DELAY at arrival of the SINGLE word
single_fine  out  7  from_roc[6:0] of the SINGLE word
idle_ok  out  1  pulse: IDLE word passed all checks
err_pulse  out  1  pulse: error detected
err_code  out  2  error type, held until next error; 0 none, 1 header, 2 sequence, 3 counter mismatch

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Word arriving on from_roc at edge t produces registered outputs visible after edge t+1. Latency is 1 cycle; one word per cycle.
- Word classes:
  - from_roc[7:6]=01: IDLE. Phase k = [3:2]; nibble = {[5:4],[1:0]}.
  - [7]=1: SINGLE.
  - [7:6]=00: header error (code 1).
- exp = (local_ctr - LINK_DELAY) mod 2^16, computed from local_ctr at the same edge the word is sampled.
- IDLE phase k checks:
  - nibble == exp[4k+3:4k].
  - k == exp_phase when seq_valid.
- Sequence tracking:
  - After an IDLE with phase k: exp_phase = (k+1) mod 4, seq_valid=1.
  - After a SINGLE: exp_phase = 0, seq_valid=1.
  - After a header error, or out of reset: seq_valid=0, and any phase is accepted.
- Error priority: header > sequence (code 2) > mismatch (code 3). Exactly one err_pulse per bad word.
- The sequence check also updates exp_phase from the received k, so the tracker resynchronises after one bad word.
- Lock FSM, states HUNT, CHECK, LOCKED:
  - HUNT: good IDLE → CHECK with good_cnt=1. If LOCK_COUNT=1, go directly to LOCKED.
  - CHECK: each good IDLE increments good_cnt. When good_cnt reaches LOCK_COUNT → LOCKED. Any error → HUNT, good_cnt=0.
  - LOCKED: any error → HUNT; locked drops on the same output edge as err_pulse.
  - SINGLE words neither advance nor reset good_cnt.
- locked = (state==LOCKED) registered. It rises on the output edge of the LOCK_COUNT-th good IDLE.
- single_valid asserts only when the FSM is LOCKED at the edge the SINGLE word is processed. Singles received while not locked are discarded.
- single_ts and single_fine update only on single_valid and hold otherwise.
- Counter arithmetic wraps mod 2^16. The exp nibble at local_ctr wrap (0xFFFF→0x0000) follows normal modular subtraction.
- Reset values: locked=0, single_valid=0, single_ts=0, single_fine=0, idle_ok=0, err_pulse=0, err_code=0, state=HUNT, good_cnt=0, seq_valid=0, exp_phase=0.
- Reset asserted mid-stream: all of the above are restored on that edge and the word sampled that edge is ignored.

Optional Feature:
RX_ERR_COUNT_EN:
- Defined: adds output err_count (16 bits) counting err_pulse events, saturating at 0xFFFF, and input err_clr (1 bit).
  - err_clr clears err_count to 0 on the next edge.
  - If err_clr and an error coincide, the result is 0.
  - err_count resets to 0.
- Undefined: neither port exists and no counter logic is generated; all other behaviour is identical.

Test Plan:
- Clean stream: ROCSTAR-model words with clk_ctr = local_ctr, LINK_DELAY=1, LOCK_COUNT=8, starting at local_ctr=0x1230 → idle_ok each cycle; locked=1 one cycle after the 8th IDLE; err_pulse never.
- Single while locked: inject 0x80 at a cycle where local_ctr=0x2001 → single_valid one cycle later with single_ts=0x2000, single_fine=0. The next word must be phase 0 and is accepted without sequence error.
- Counter mismatch: corrupt the nibble of one phase-2 word by XOR 0x1 while locked → err_pulse, err_code=3, locked=0 on the same edge; re-lock after 8 further good IDLEs.
- Framing and sequence errors:
  - Word 0x00 → err_code=1, and the following IDLE of any phase is accepted.
  - Phase sequence 0,1,3 → err_code=2 on the phase-3 word.
- Wrap and reset:
  - local_ctr passes 0xFFFF→0x0000 during phase-0 words → no errors.
  - Assert rst for 1 cycle while locked → all outputs 0; a single sent the next cycle is discarded (single_valid=0).
- With RX_ERR_COUNT_EN: inject 3 errors → err_count=3. Pulse err_clr coincident with a 4th error → err_count=0. Force 0xFFFF with further errors → err_count stays 0xFFFF.
